// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op-select bit positions
// and the FSM state type.
package md_pkg;

    localparam int unsigned MD_MUL    = 7;
    localparam int unsigned MD_MULH   = 6;
    localparam int unsigned MD_MULHSU = 5;
    localparam int unsigned MD_MULHU  = 4;
    localparam int unsigned MD_DIV    = 3;
    localparam int unsigned MD_DIVU   = 2;
    localparam int unsigned MD_REM    = 1;
    localparam int unsigned MD_REMU   = 0;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } md_state_t;

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module md_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             dividend_bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             quot_bit_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial = {rem_i, dividend_bit_i};
        diff  = trial - {1'b0, divisor_i};
        // rem_i < divisor_i keeps a non-negative diff below 2^WIDTH, so the top bit is the borrow
        quot_bit_o = ~diff[WIDTH];
        rem_o      = quot_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up applied when the result is loaded.
module alu_muldiv
    import md_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           md_info_i,
    input  logic [WIDTH-1:0]     rs1_data_i,
    input  logic [WIDTH-1:0]     rs2_data_i,
    input  logic [REG_WIDTH-1:0] rd_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 flush_i,
    output logic [WIDTH-1:0]     result_o,
    output logic [REG_WIDTH-1:0] rd_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy_o
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};

    md_state_t state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [REG_WIDTH-1:0] rd_q, rd_d;
    logic                 is_mul_q, is_mul_d;
    logic                 sel_hi_q, sel_hi_d;
    logic                 neg_q, neg_d;

    // Request decode
    logic             req_is_mul, req_is_div, req_s1, req_s2;
    logic [WIDTH-1:0] req_mag1, req_mag2;
    logic             req_neg, req_sel_hi, req_div_zero, req_ovf;
    logic [WIDTH-1:0] req_special;

    always_comb begin
        req_is_mul = |md_info_i[7:4];
        req_is_div = |md_info_i[3:0];
        req_s1 = rs1_data_i[WIDTH-1] & (md_info_i[MD_MULH] | md_info_i[MD_MULHSU] |
                                        md_info_i[MD_DIV] | md_info_i[MD_REM]);
        req_s2 = rs2_data_i[WIDTH-1] & (md_info_i[MD_MULH] | md_info_i[MD_DIV] |
                                        md_info_i[MD_REM]);
        req_mag1 = req_s1 ? -rs1_data_i : rs1_data_i;
        req_mag2 = req_s2 ? -rs2_data_i : rs2_data_i;
        req_neg = 1'b0;
        if (md_info_i[MD_MULH] || md_info_i[MD_MULHSU] || md_info_i[MD_DIV]) begin
            req_neg = req_s1 ^ req_s2;
        end else if (md_info_i[MD_REM]) begin
            req_neg = req_s1;
        end
        // Upper product half for the high multiplies; remainder for REM/REMU
        req_sel_hi = md_info_i[MD_MULH] | md_info_i[MD_MULHSU] | md_info_i[MD_MULHU] |
                     md_info_i[MD_REM] | md_info_i[MD_REMU];
        req_div_zero = req_is_div && (rs2_data_i == '0);
        req_ovf = (md_info_i[MD_DIV] | md_info_i[MD_REM]) && (rs1_data_i == MinNeg) &&
                  (rs2_data_i == '1);
        req_special = '0;
        if (req_div_zero) begin
            if (md_info_i[MD_DIV] || md_info_i[MD_DIVU]) begin
                req_special = '1;
            end else begin
                req_special = rs1_data_i;
            end
        end else if (md_info_i[MD_DIV]) begin
            req_special = rs1_data_i;
        end
    end

    // One iteration of the active datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_rem;
    logic             div_qbit;
    logic [WIDTH-1:0] step_hi, step_lo;

    md_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i          (hi_q),
        .divisor_i      (opb_q),
        .dividend_bit_i (lo_q[WIDTH-1]),
        .rem_o          (div_rem),
        .quot_bit_o     (div_qbit)
    );

    always_comb begin
        mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
        if (is_mul_q) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = div_rem;
            step_lo = {lo_q[WIDTH-2:0], div_qbit};
        end
    end

    // Final result from the last step, with sign fix-up and half selection
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_sel, fin_res;

    always_comb begin
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        div_sel  = sel_hi_q ? step_hi : step_lo;
        if (is_mul_q) begin
            fin_res = sel_hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        end else begin
            fin_res = neg_q ? -div_sel : div_sel;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        rd_d     = rd_q;
        is_mul_d = is_mul_q;
        sel_hi_d = sel_hi_q;
        neg_d    = neg_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i && !flush_i) begin
                    rd_d     = rd_i;
                    is_mul_d = req_is_mul;
                    sel_hi_d = req_sel_hi;
                    neg_d    = req_neg;
                    hi_d     = '0;
                    lo_d     = req_is_mul ? req_mag2 : req_mag1;
                    opb_d    = req_is_mul ? req_mag1 : req_mag2;
                    if (req_div_zero || req_ovf) begin
                        state_d  = DONE;
                        result_d = req_special;
                    end else begin
                        state_d = CALC;
                        cnt_d   = CntW'(WIDTH - 1);
                    end
                end
            end
            CALC: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = fin_res;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            is_mul_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            is_mul_q <= is_mul_d;
            sel_hi_q <= sel_hi_d;
            neg_q    <= neg_d;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written back-pressure, flush and reset sequences.
module tb_alu_muldiv;

    localparam logic [31:0] MinNeg = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  md_info_i;
    logic [31:0] rs1_data_i, rs2_data_i;
    logic [4:0]  rd_i;
    logic        valid_i, flush_i, ready_i;
    logic        ready_o, valid_o, busy_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int failures = 0;

    alu_muldiv #(
        .WIDTH     (32),
        .REG_WIDTH (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .md_info_i  (md_info_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_i       (rd_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .flush_i    (flush_i),
        .result_o   (result_o),
        .rd_o       (rd_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: RV32M semantics straight from integer arithmetic
    function automatic logic [31:0] model(input int idx, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] pu;
        longint      ps;
        int          q;
        logic [31:0] r;
        r = '0;
        case (idx)
            7: begin pu = {32'b0, a} * {32'b0, b}; r = pu[31:0]; end
            6: begin ps = longint'($signed(a)) * longint'($signed(b)); r = ps[63:32]; end
            5: begin ps = longint'($signed(a)) * longint'({32'b0, b}); r = ps[63:32]; end
            4: begin pu = {32'b0, a} * {32'b0, b}; r = pu[63:32]; end
            3: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == MinNeg && b == 32'hFFFF_FFFF) r = MinNeg;
                else begin q = $signed(a) / $signed(b); r = q; end
            end
            2: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            1: begin
                if (b == 0) r = a;
                else if (a == MinNeg && b == 32'hFFFF_FFFF) r = 0;
                else begin q = $signed(a) % $signed(b); r = q; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input int idx, input logic [31:0] a, input logic [31:0] b);
        if (idx <= 3 && b == 0) return 1;
        if ((idx == 3 || idx == 1) && a == MinNeg && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, wait for the result, hold back-pressure for `stall` cycles, then handshake.
    task automatic do_op(input string tag, input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int stall,
                         input logic [31:0] exp, input int exp_lat);
        int guard = 0;
        int lat;
        while (!ready_o && guard < 100) begin step(); guard++; end
        chk({tag, "_ready_before_accept"}, 32'(ready_o), 32'd1);
        md_info_i = '0;
        md_info_i[idx] = 1'b1;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_i = rd;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        md_info_i = '0;
        lat = 1;
        while (!valid_o && lat < 100) begin step(); lat++; end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_result"}, result_o, exp);
        chk({tag, "_rd"}, 32'(rd_o), 32'(rd));
        for (int i = 0; i < stall; i++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(valid_o), 32'd1);
            chk({tag, "_hold_result"}, result_o, exp);
            chk({tag, "_hold_rd"}, 32'(rd_o), 32'(rd));
        end
        ready_i = 1'b1;
        chk({tag, "_ready_during_handshake"}, 32'(ready_o), 32'd0);
        step();
        ready_i = 1'b0;
        chk({tag, "_valid_after_handshake"}, 32'(valid_o), 32'd0);
        chk({tag, "_ready_after_handshake"}, 32'(ready_o), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return MinNeg;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[10];

    initial begin
        int          vpulses;
        logic [31:0] a, b;
        int          idx;

        vecs[0] = '{7, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1] = '{6, MinNeg,        MinNeg,        32'h4000_0000, 33};
        vecs[2] = '{4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3] = '{5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4] = '{3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5] = '{1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6] = '{2, 32'd100,       32'd7,         32'd14,        33};
        vecs[7] = '{0, 32'd100,       32'd7,         32'd2,         33};
        vecs[8] = '{3, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9] = '{0, 32'd5,         32'd0,         32'd5,         1};

        rst_n = 1'b0;
        md_info_i = '0;
        rs1_data_i = '0;
        rs2_data_i = '0;
        rd_i = '0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        step();
        step();
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        chk("reset_rd", 32'(rd_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, 5'(i + 3), 0,
                  vecs[i].exp, vecs[i].lat);
        end
        do_op("div_ovf", 3, MinNeg, 32'hFFFF_FFFF, 5'd21, 0, MinNeg, 1);
        do_op("rem_ovf", 1, MinNeg, 32'hFFFF_FFFF, 5'd22, 0, 32'd0, 1);

        // Back-pressure on a normal and a special-case result
        do_op("bp_mul", 7, 32'd7, 32'hFFFF_FFFD, 5'd9, 5, 32'hFFFF_FFEB, 33);
        do_op("bp_div0", 2, 32'd9, 32'd0, 5'd10, 5, 32'hFFFF_FFFF, 1);

        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 7);
            a = pick();
            b = pick();
            do_op($sformatf("rnd%0d_op%0d", n, idx), idx, a, b, 5'($urandom_range(0, 31)),
                  $urandom_range(0, 3), model(idx, a, b), model_lat(idx, a, b));
        end

        // Flush on the 10th CALC cycle
        md_info_i = 8'h04;
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd3;
        rd_i = 5'd7;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        md_info_i = '0;
        chk("flush_busy_in_calc", 32'(busy_o), 32'd1);
        repeat (9) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_valid", 32'(valid_o), 32'd0);
        chk("flush_ready", 32'(ready_o), 32'd1);
        chk("flush_busy", 32'(busy_o), 32'd0);
        vpulses = 0;
        repeat (40) begin step(); if (valid_o) vpulses++; end
        chk("flush_no_valid_later", 32'(vpulses), 32'd0);

        // Simultaneous valid and flush in IDLE is not accepted
        md_info_i = 8'h80;
        rs1_data_i = 32'd3;
        rs2_data_i = 32'd4;
        valid_i = 1'b1;
        flush_i = 1'b1;
        step();
        valid_i = 1'b0;
        flush_i = 1'b0;
        md_info_i = '0;
        chk("vf_busy", 32'(busy_o), 32'd0);
        chk("vf_ready", 32'(ready_o), 32'd1);
        vpulses = 0;
        repeat (40) begin step(); if (valid_o) vpulses++; end
        chk("vf_no_valid", 32'(vpulses), 32'd0);

        // Flush in DONE with ready_i high still kills the result
        md_info_i = 8'h08;
        rs1_data_i = 32'd5;
        rs2_data_i = 32'd0;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        md_info_i = '0;
        chk("done_flush_pre_valid", 32'(valid_o), 32'd1);
        flush_i = 1'b1;
        ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        ready_i = 1'b0;
        chk("done_flush_valid", 32'(valid_o), 32'd0);
        chk("done_flush_ready", 32'(ready_o), 32'd1);

        // Reset mid-CALC
        md_info_i = 8'h40;
        rs1_data_i = 32'h1234_5678;
        rs2_data_i = 32'h0FED_CBA9;
        rd_i = 5'd17;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        md_info_i = '0;
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_valid", 32'(valid_o), 32'd0);
        chk("rst_mid_result", result_o, 32'd0);
        chk("rst_mid_rd", 32'(rd_o), 32'd0);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_ready", 32'(ready_o), 32'd1);
        vpulses = 0;
        repeat (40) begin step(); if (valid_o) vpulses++; end
        chk("rst_mid_no_valid", 32'(vpulses), 32'd0);

        do_op("post_reset", 2, 32'd100, 32'd7, 5'd30, 0, 32'd14, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative RV32M multiply/divide execute unit, parametrised in data width, that sits beside the single-cycle integer ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake and computes in a multi-cycle FSM. It returns the result with its destination-register tag over a second valid/ready handshake. A flush input lets the pipeline kill an in-flight operation on redirect.

## Interface
- `WIDTH`, default 32: operand/result width; must be ≥ 4 and even.
- `REG_WIDTH`, default 5: destination-register tag width.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `md_info_i`  in  8: one-hot op select. Bit 7 MUL, 6 MULH, 5 MULHSU, 4 MULHU, 3 DIV, 2 DIVU, 1 REM, 0 REMU.
- `rs1_data_i`  in  WIDTH: operand 1 (multiplicand / dividend).
- `rs2_data_i`  in  WIDTH: operand 2 (multiplier / divisor).
- `rd_i`  in  REG_WIDTH: destination tag, passed through to `rd_o`.
- `valid_i`  in  1: request valid.
- `ready_o`  out  1: unit can accept; high only in IDLE.
- `flush_i`  in  1: kill the in-flight or offered operation.
- `result_o`  out  WIDTH: result; held stable while `valid_o` is high.
- `rd_o`  out  REG_WIDTH: tag of `result_o`.
- `valid_o`  out  1: result valid.
- `ready_i`  in  1: consumer accepts result.
- `busy_o`  out  1: state ≠ IDLE, for hazard stall.

## Operation
- States:
  - IDLE: `ready_o` = 1.
  - CALC: iterating.
  - DONE: `valid_o` = 1.
- IDLE → CALC on `valid_i & ready_o & ~flush_i`. Latch the operands, the op and `rd_i`, and load the iteration counter with WIDTH−1.
- IDLE → DONE directly, with no CALC, for the special divide cases:
  - Divisor = 0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow, DIV/REM with rs1 = 1 followed by WIDTH−1 zeros and rs2 = all ones: DIV = rs1; REM = 0.
- Multiply:
  - Take magnitudes of the signed operands (MULH: both signed; MULHSU: rs1 signed, rs2 unsigned; MULHU/MUL: unsigned path, since MUL low half is sign-agnostic).
  - Form an unsigned 2·WIDTH product by shift-add, one multiplier bit per CALC cycle.
  - Negate the product if the operand signs differ.
  - MUL returns bits [WIDTH−1:0]; MULH/MULHSU/MULHU return bits [2·WIDTH−1:WIDTH].
- Divide:
  - Restoring, one quotient bit per CALC cycle, on magnitudes for DIV/REM.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
  - DIVU/REMU use no sign fix-up.
- Sign fix-up and half selection are applied when loading `result_o` on the CALC → DONE edge.
- CALC → DONE when the counter = 0 at a clock edge.
- DONE → IDLE on `valid_o & ready_i`. No new request is accepted in that same cycle; `ready_o` rises the following cycle.
- `flush_i` in any state forces IDLE at the next edge and clears `valid_o`; the result is discarded.
- `flush_i` has priority over `valid_i` and over `ready_i`. A flush in DONE with `ready_i` high still counts as a kill for verification purposes.
- `md_info_i` not one-hot when accepted: behaviour is undefined. The bench must not drive it.

## Timing
- Reset (sampled `rst_n` = 0): state IDLE; `valid_o` = 0, `result_o` = 0, `rd_o` = 0, `busy_o` = 0, `ready_o` = 1 from the first cycle after reset.
- Reset mid-CALC or mid-DONE behaves exactly as reset: the operation is lost and no `valid_o` pulse occurs.
- Normal latency: `valid_o` first high WIDTH+1 cycles after the accept edge (33 for WIDTH = 32).
- Special-case latency: `valid_o` high 1 cycle after the accept edge.
- Back-pressure: `result_o`/`rd_o`/`valid_o` hold unchanged while `ready_i` = 0, for any number of cycles.
- Throughput: one op per WIDTH+2 cycles when `ready_i` is held high.
- Counter width: $clog2(WIDTH). It wraps only through reload, never by free-running.

## Structure
- Shared package `md_pkg`:
  - one-hot bit-index constants for `md_info_i` (`MD_MUL` … `MD_REMU`);
  - state enum `md_state_t` {IDLE, CALC, DONE}.
- One sub-module, `md_div_step`: combinational restoring step (remainder, divisor, dividend bit in; next remainder and quotient bit out), instantiated once.
- Multiply shift-add, sign handling and the FSM live in `alu_muldiv`.

## Test plan
- MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB, `rd_o` = `rd_i`, `valid_o` exactly 33 cycles after accept.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000;
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF;
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero and overflow, each with `valid_o` 1 cycle after accept:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5;
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Back-pressure: hold `ready_i` = 0 for 5 cycles after `valid_o` rises → outputs stable; `ready_o` = 1 the cycle after the handshake.
- Flush and reset:
  - `flush_i` on the 10th CALC cycle → no `valid_o`, `ready_o` = 1 next cycle;
  - a simultaneous `valid_i` + `flush_i` in IDLE is not accepted;
  - `rst_n` = 0 mid-CALC → all outputs 0 next cycle.
